// File: rtl/pool_window_2x2.sv
// 2x2 window extractor for a raster pixel stream: buffers one even row, then
// emits {top-left, top-right, bottom-left, bottom-right} windows on odd rows.
module pool_window_2x2 #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic signed [DATA_WIDTH-1:0] pixel_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic signed [DATA_WIDTH-1:0] window_o [0:3],
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         last_o
);

  localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]                 col_r, col_nxt_s, col_m1_s;
  logic [RW-1:0]                 row_r, row_nxt_s;
  logic signed [DATA_WIDTH-1:0]  linebuf_r [0:IMG_WIDTH-1];
  logic signed [DATA_WIDTH-1:0]  hold_bl_r;
  logic                          in_xfer_s, out_xfer_s, load_s, load_last_s;

  // Handshake decode; a window loads on the bottom-right pixel of each 2x2 block.
  always_comb begin
    ready_o     = !(valid_o && !ready_i);
    in_xfer_s   = valid_i && ready_o;
    out_xfer_s  = valid_o && ready_i;
    load_s      = in_xfer_s && row_r[0] && col_r[0];
    load_last_s = load_s && (row_r == ROW_LAST) && (col_r == COL_LAST);
    col_m1_s    = col_r - CW'(1);
  end

  // Raster position next-state: advances only on an accepted pixel.
  always_comb begin
    col_nxt_s = col_r;
    row_nxt_s = row_r;
    if (in_xfer_s) begin
      if (col_r == COL_LAST) begin
        col_nxt_s = {CW{1'b0}};
        if (row_r == ROW_LAST) begin
          row_nxt_s = {RW{1'b0}};
        end else begin
          row_nxt_s = row_r + RW'(1);
        end
      end else begin
        col_nxt_s = col_r + CW'(1);
        row_nxt_s = row_r;
      end
    end else begin
      col_nxt_s = col_r;
      row_nxt_s = row_r;
    end
  end

  // Raster position registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_r <= {CW{1'b0}};
      row_r <= {RW{1'b0}};
    end else begin
      col_r <= col_nxt_s;
      row_r <= row_nxt_s;
    end
  end

  // Pixel storage; contents are only meaningful once rewritten, so no reset.
  always_ff @(posedge clk_i) begin
    if (in_xfer_s && !row_r[0]) begin
      linebuf_r[col_r] <= pixel_i;
    end
    if (in_xfer_s && row_r[0] && !col_r[0]) begin
      hold_bl_r <= pixel_i;
    end
  end

  // Output window register: load wins over clear so back-to-back windows have no bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        window_o[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (load_s) begin
      valid_o     <= 1'b1;
      last_o      <= load_last_s;
      window_o[0] <= linebuf_r[col_m1_s];
      window_o[1] <= linebuf_r[col_r];
      window_o[2] <= hold_bl_r;
      window_o[3] <= pixel_i;
    end else if (out_xfer_s) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else begin
      valid_o <= valid_o;
      last_o  <= last_o;
    end
  end

endmodule

// File: tb/tb_pool_window_2x2.sv
// Directed + randomized bench for pool_window_2x2 on a 4x4 image; expected
// windows are queued as pixels are sent and compared on each output transfer.
module tb_pool_window_2x2;

  localparam int DW = 32;
  localparam int W  = 4;
  localparam int H  = 4;

  typedef struct packed {
    logic [DW-1:0] w0;
    logic [DW-1:0] w1;
    logic [DW-1:0] w2;
    logic [DW-1:0] w3;
    logic          last;
  } win_t;

  logic                 clk = 1'b0;
  logic                 rst_i = 1'b1;
  logic signed [DW-1:0] pixel_i = '0;
  logic                 valid_i = 1'b0;
  logic                 ready_o;
  logic signed [DW-1:0] window_o [0:3];
  logic                 valid_o;
  logic                 ready_i = 1'b1;
  logic                 last_o;

  int compared = 0;
  int mismatched = 0;
  int tb_col = 0;
  int tb_row = 0;
  int gap_max = 0;
  bit bp_random = 1'b0;
  logic ready_force = 1'b1;
  logic signed [DW-1:0] frame_pix [0:W*H-1];
  win_t exp_q [$];

  pool_window_2x2 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk_i(clk), .rst_i(rst_i), .pixel_i(pixel_i), .valid_i(valid_i),
    .ready_o(ready_o), .window_o(window_o), .valid_o(valid_o),
    .ready_i(ready_i), .last_o(last_o)
  );

  always #5 clk = ~clk;

  // Downstream backpressure driver.
  always begin
    @(posedge clk);
    #2;
    ready_i = bp_random ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Scoreboard: every output transfer must match the oldest expected window.
  always @(negedge clk) begin
    win_t got;
    win_t exp;
    if (!rst_i && valid_o && ready_i) begin
      got = {window_o[0], window_o[1], window_o[2], window_o[3], last_o};
      exp = '0;
      compared++;
      assert (exp_q.size() != 0) else begin
        mismatched++;
        $error("FAIL extra_window got=%h expected none", got);
      end
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        compared++;
        assert (got === exp) else begin
          mismatched++;
          $error("FAIL window got=%h expected=%h", got, exp);
        end
      end
    end
  end

  task automatic send_pixel(input logic signed [DW-1:0] v);
    bit acc = 1'b0;
    int waited = 0;
    valid_i = 1'b1;
    pixel_i = v;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      waited++;
    end
    valid_i = 1'b0;
    compared++;
    assert (acc === 1'b1) else begin
      mismatched++;
      $error("FAIL accept_timeout got=%0b expected=1", acc);
    end
    if ((tb_row % 2 == 1) && (tb_col % 2 == 1)) begin
      compared++;
      assert (valid_o === 1'b1) else begin
        mismatched++;
        $error("FAIL latency r%0d c%0d valid_o=%b expected=1", tb_row, tb_col, valid_o);
      end
    end
    if (tb_col == W - 1) begin
      tb_col = 0;
      tb_row = (tb_row == H - 1) ? 0 : tb_row + 1;
    end else begin
      tb_col++;
    end
    repeat ($urandom_range(0, gap_max)) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Queue every window whose bottom-right pixel lies within the first n pixels.
  task automatic push_expected(input int n);
    win_t e;
    for (int r = 0; r < H; r += 2) begin
      for (int c = 0; c < W; c += 2) begin
        if ((r + 1) * W + c + 1 < n) begin
          e.w0 = frame_pix[r * W + c];
          e.w1 = frame_pix[r * W + c + 1];
          e.w2 = frame_pix[(r + 1) * W + c];
          e.w3 = frame_pix[(r + 1) * W + c + 1];
          e.last = (r == H - 2) && (c == W - 2);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic send_frame(input int n);
    push_expected(n);
    for (int i = 0; i < n; i++) send_pixel(frame_pix[i]);
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 500) begin
      @(posedge clk);
      waited++;
    end
    repeat (3) @(posedge clk);
    #1;
    compared++;
    assert (exp_q.size() == 0) else begin
      mismatched++;
      $error("FAIL drain pending=%0d expected=0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    compared++;
    assert ({valid_o, last_o, ready_o} === 3'b001) else begin
      mismatched++;
      $error("FAIL reset_ctrl got v/l/r=%b%b%b expected=001", valid_o, last_o, ready_o);
    end
    compared++;
    assert ({window_o[0], window_o[1], window_o[2], window_o[3]} === {4*DW{1'b0}}) else begin
      mismatched++;
      $error("FAIL reset_window got=%h %h %h %h expected=0", window_o[0], window_o[1],
             window_o[2], window_o[3]);
    end
    rst_i = 1'b0;
    tb_col = 0;
    tb_row = 0;
  endtask

  task automatic fill_ramp(input int base);
    for (int i = 0; i < W * H; i++) frame_pix[i] = DW'(base + i);
  endtask

  initial begin
    do_reset();

    // Basic frame 0..15 with ready_i=1.
    fill_ramp(0);
    send_frame(W * H);
    drain();

    // Stall while window {0,1,4,5} is pending.
    fill_ramp(0);
    push_expected(W * H);
    ready_force = 1'b0;
    @(posedge clk);
    #3;
    for (int i = 0; i < 6; i++) send_pixel(frame_pix[i]);
    valid_i = 1'b1;
    pixel_i = frame_pix[6];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      compared++;
      assert (ready_o === 1'b0 && valid_o === 1'b1) else begin
        mismatched++;
        $error("FAIL stall_ctrl ready_o=%b valid_o=%b expected=0/1", ready_o, valid_o);
      end
      compared++;
      assert ({window_o[0], window_o[1], window_o[2], window_o[3]} ===
              {32'sd0, 32'sd1, 32'sd4, 32'sd5}) else begin
        mismatched++;
        $error("FAIL stall_window got=%0d %0d %0d %0d expected=0 1 4 5", window_o[0],
               window_o[1], window_o[2], window_o[3]);
      end
      @(posedge clk);
      #1;
    end
    ready_force = 1'b1;
    for (int i = 6; i < W * H; i++) send_pixel(frame_pix[i]);
    drain();

    // Two back-to-back frames.
    fill_ramp(0);
    send_frame(W * H);
    fill_ramp(100);
    send_frame(W * H);
    drain();

    // Signed extremes in one window.
    fill_ramp(-8);
    frame_pix[0] = -32'sd1;
    frame_pix[1] = {1'b1, {(DW-1){1'b0}}};
    frame_pix[4] = {1'b0, {(DW-1){1'b1}}};
    frame_pix[5] = 32'sh8000_0001;
    send_frame(W * H);
    drain();

    // Reset after pixel 6 of a frame, then a clean frame.
    fill_ramp(0);
    send_frame(7);
    drain();
    do_reset();
    send_frame(W * H);
    drain();

    // Random input gaps and random backpressure over several frames.
    bp_random = 1'b1;
    gap_max = 3;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < W * H; i++) frame_pix[i] = $urandom;
      send_frame(W * H);
    end
    bp_random = 1'b0;
    gap_max = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
